// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
// Shared constants and helpers for the 16-bit Fibonacci LFSR.
//   LFSR_W       : state width
//   DEFAULT_SEED : reset / restart state (non-zero)
//   DEFAULT_TAPS : feedback tap mask, bits 15,13,12,10 (x^16+x^14+x^13+x^11+1)
//   PERIOD       : number of shifts before DEFAULT_SEED recurs
// ----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int unsigned LFSR_W = 16;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'h0001;
    localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 16'hB400;

    localparam int unsigned PERIOD = 65535;

    // Feedback bit: parity of the tapped state bits.
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] state,
                                     input logic [LFSR_W-1:0] taps);
        return ^(state & taps);
    endfunction

    // One Fibonacci step: shift toward the MSB, feedback enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state,
                                                    input logic [LFSR_W-1:0] taps);
        return {state[LFSR_W-2:0], lfsr_fb(state, taps)};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// ----------------------------------------------------------------------------
// lfsr_step
// Combinational next-state logic for the Fibonacci LFSR.
//   state      in  LFSR_W  current register value
//   taps       in  LFSR_W  feedback tap mask
//   next_state out LFSR_W  value after one shift
//   fb         out 1       feedback bit shifted into bit 0
// ----------------------------------------------------------------------------
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] state,
    input  logic [LFSR_W-1:0] taps,
    output logic [LFSR_W-1:0] next_state,
    output logic              fb
);

    always_comb begin
        fb         = lfsr_fb(state, taps);
        next_state = lfsr_next(state, taps);
    end

endmodule

// File: rtl/lfsr16.sv
// ----------------------------------------------------------------------------
// lfsr16
// 16-bit maximal-length Fibonacci LFSR with shift enable, shift counter and a
// one-cycle period-complete flag. All outputs are registered.
//   clk          in  1   system clock, rising edge
//   rst_n        in  1   asynchronous active-low reset
//   sh_en        in  1   one LFSR step per clock while high
//   Q_out        out 16  current LFSR state
//   ticks        out 16  shifts since reset or the last period wrap
//   max_tick_reg out 1   pulse: the shift just taken returned the state to SEED
// ----------------------------------------------------------------------------
module lfsr16
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
    parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sh_en,
    output logic [LFSR_W-1:0] Q_out,
    output logic [LFSR_W-1:0] ticks,
    output logic              max_tick_reg
);

    logic [LFSR_W-1:0] next_state;
    logic              fb_unused;
    logic              seed_next;
    logic              locked_up;

    lfsr_step u_step (
        .state      (Q_out),
        .taps       (TAPS),
        .next_state (next_state),
        .fb         (fb_unused)
    );

    assign seed_next = (next_state == SEED);
    // All-zero is a fixed point of an XOR LFSR; it cannot be reached from a
    // non-zero seed, but an upset could land there, so recover regardless of sh_en.
    assign locked_up = (Q_out == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q_out        <= SEED;
            ticks        <= '0;
            max_tick_reg <= 1'b0;
        end else begin
            max_tick_reg <= 1'b0;
            if (locked_up) begin
                Q_out <= SEED;
                ticks <= '0;
            end else if (sh_en) begin
                Q_out <= next_state;
                if (seed_next) begin
                    // Wrap: ticks spans 0..PERIOD-1 and restarts with the sequence.
                    ticks        <= '0;
                    max_tick_reg <= 1'b1;
                end else begin
                    ticks <= ticks + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr16.sv
module tb_lfsr16;

    logic        clk;
    logic        rst_n;
    logic        sh_en;
    logic [15:0] Q_out;
    logic [15:0] ticks;
    logic        max_tick_reg;

    int checks = 0;
    int errors = 0;

    bit seen [0:65535];

    lfsr16 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sh_en        (sh_en),
        .Q_out        (Q_out),
        .ticks        (ticks),
        .max_tick_reg (max_tick_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    initial begin
        logic [15:0] q;
        logic [15:0] model;
        int repeat_err;
        int model_err;
        int tick_err;
        int pulse_cnt;

        rst_n = 1'b0;
        sh_en = 1'b0;
        #100;
        check("reset_q", 32'(Q_out), 32'h0001);
        check("reset_ticks", 32'(ticks), 32'h0);
        check("reset_pulse", 32'(max_tick_reg), 32'h0);

        // Release away from the clock edge, then 15 enabled shifts.
        @(posedge clk); #1;
        rst_n = 1'b1;
        sh_en = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            case (i)
                10: check("shift10", 32'(Q_out), 32'h0400);
                11: check("shift11", 32'(Q_out), 32'h0801);
                12: check("shift12", 32'(Q_out), 32'h1002);
                13: check("shift13", 32'(Q_out), 32'h2005);
                14: check("shift14", 32'(Q_out), 32'h400B);
                15: check("shift15", 32'(Q_out), 32'h8016);
                default: ;
            endcase
        end
        check("ticks15", 32'(ticks), 32'd15);
        check("pulse15", 32'(max_tick_reg), 32'h0);

        // Hold for 5 clocks.
        sh_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_q", 32'(Q_out), 32'h8016);
            check("hold_ticks", 32'(ticks), 32'd15);
            check("hold_pulse", 32'(max_tick_reg), 32'h0);
        end

        // Resume: 8016 -> 002D.
        sh_en = 1'b1;
        tick();
        check("resume_q", 32'(Q_out), 32'h002D);
        check("resume_ticks", 32'(ticks), 32'd16);

        // Full period from reset.
        sh_en = 1'b0;
        rst_n = 1'b0;
        #20;
        check("reset2_q", 32'(Q_out), 32'h0001);
        check("reset2_ticks", 32'(ticks), 32'h0);
        rst_n = 1'b1;
        sh_en = 1'b1;
        for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
        seen[16'h0001] = 1'b1;
        model      = 16'h0001;
        repeat_err = 0;
        model_err  = 0;
        tick_err   = 0;
        pulse_cnt  = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            q     = Q_out;
            model = ref_next(model);
            if (q !== model) model_err++;
            if (i < 65535) begin
                if (q == 16'h0000 || seen[q]) repeat_err++;
                seen[q] = 1'b1;
            end
            if (ticks !== 16'(i % 65535)) tick_err++;
            if (max_tick_reg === 1'b1) pulse_cnt++;
        end
        check("period_model_err", 32'(model_err), 32'd0);
        check("period_repeat_err", 32'(repeat_err), 32'd0);
        check("period_ticks_err", 32'(tick_err), 32'd0);
        check("period_pulse_count", 32'(pulse_cnt), 32'd1);
        check("wrap_q", 32'(Q_out), 32'h0001);
        check("wrap_ticks", 32'(ticks), 32'h0);
        check("wrap_pulse", 32'(max_tick_reg), 32'h1);
        sh_en = 1'b0;
        tick();
        check("wrap_pulse_drop", 32'(max_tick_reg), 32'h0);
        check("wrap_hold_q", 32'(Q_out), 32'h0001);

        // Asynchronous reset between edges at ticks=500.
        sh_en = 1'b1;
        for (int i = 0; i < 500; i++) tick();
        check("ticks500", 32'(ticks), 32'd500);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_q", 32'(Q_out), 32'h0001);
        check("async_ticks", 32'(ticks), 32'h0);
        check("async_pulse", 32'(max_tick_reg), 32'h0);
        tick();
        check("async_hold_q", 32'(Q_out), 32'h0001);
        check("async_hold_ticks", 32'(ticks), 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_reset_q", 32'(Q_out), 32'h0002);
        check("post_reset_ticks", 32'(ticks), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
